// File: rtl/saes_pkg.sv
// Shared constants, tables and state type for the 64-bit Simplified-AES datapath.
package saes_pkg;

  localparam int STATE_W = 64;
  localparam int WORD_W  = 16;
  localparam int NIB_W   = 4;

  localparam logic [NIB_W-1:0] SBOX [16] = '{
    4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
    4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7
  };

  // Entry 0 holds the constant for round 1.
  localparam logic [NIB_W-1:0] RCON [10] = '{
    4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB, 4'h5, 4'hA
  };

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  function automatic logic [NIB_W-1:0] rcon_of(input logic [3:0] round);
    logic [3:0] pos;
    pos = round - 4'd1;
    if (round >= 4'd1 && round <= 4'd10)
      return RCON[pos];
    return '0;
  endfunction

endpackage

// File: rtl/sbox_nibble.sv
// 4-bit S-box lookup; shared by key expansion and the SubNibbles stage.
import saes_pkg::*;

module sbox_nibble (
  input  logic [NIB_W-1:0] nib,
  output logic [NIB_W-1:0] sub
);

  assign sub = SBOX[nib];

endmodule

// File: rtl/key_schedule.sv
// Sequential round-key generator: emits NR+1 keys, one per valid/ready handshake.
import saes_pkg::*;

module key_schedule #(
  parameter int NR = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [STATE_W-1:0]  cipherKey,
  output logic                busy,
  output logic [STATE_W-1:0]  roundKey,
  output logic [3:0]          roundIdx,
  output logic                keyValid,
  input  logic                keyReady,
  output logic                done
);

  localparam logic [3:0] LAST = 4'(NR);

  state_t             state, state_nx;
  logic [STATE_W-1:0] key_q, key_nx;
  logic [3:0]         idx_q, idx_nx;
  logic               done_q, done_nx;

  logic [WORD_W-1:0]  w0, w1, w2, w3;
  logic [WORD_W-1:0]  rot, sub_w, g;
  logic [WORD_W-1:0]  w0n, w1n, w2n, w3n;
  logic [3:0]         round_nx;
  logic [STATE_W-1:0] next_key;

  assign w0 = key_q[63:48];
  assign w1 = key_q[47:32];
  assign w2 = key_q[31:16];
  assign w3 = key_q[15:0];

  assign rot = {w3[11:0], w3[15:12]};

  for (genvar n = 0; n < 4; n++) begin : g_subnib
    sbox_nibble u_sbox (
      .nib (rot[n*NIB_W +: NIB_W]),
      .sub (sub_w[n*NIB_W +: NIB_W])
    );
  end

  assign round_nx = idx_q + 4'd1;
  assign g        = sub_w ^ {rcon_of(round_nx), 12'h000};
  assign w0n      = w0 ^ g;
  assign w1n      = w1 ^ w0n;
  assign w2n      = w2 ^ w1n;
  assign w3n      = w3 ^ w2n;
  assign next_key = {w0n, w1n, w2n, w3n};

  always_comb begin
    state_nx = state;
    key_nx   = key_q;
    idx_nx   = idx_q;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        // The done cycle is already IDLE, so start is masked by the done pulse.
        if (start && !done_q) begin
          key_nx   = cipherKey;
          idx_nx   = '0;
          state_nx = EMIT;
        end
      end
      EMIT: begin
        if (keyReady) begin
          if (idx_q == LAST) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else begin
            key_nx = next_key;
            idx_nx = round_nx;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      key_q  <= '0;
      idx_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      key_q  <= key_nx;
      idx_q  <= idx_nx;
      done_q <= done_nx;
    end
  end

  assign keyValid = (state == EMIT);
  assign busy     = (state == EMIT);
  assign done     = done_q;
  assign roundKey = key_q;
  assign roundIdx = idx_q;

endmodule

// File: doc/key_schedule.md
Name: key_schedule

Overview:
- Sequential round-key generator for the 64-bit Simplified-AES datapath.
- Sits directly upstream of the AddRoundKey stage and drives its 64-bit roundKey input.
- Expands a 64-bit cipher key into NR+1 round keys and emits one key per valid/ready handshake, with round 0 equal to the cipher key.

Parameters:
- NR, 4: number of rounds; legal range 1..10; keys emitted = NR+1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin expansion; sampled only in IDLE
- cipherKey  input  64  cipher key, captured on accepted start
- busy  output  1  high from accepted start until the final key is accepted
- roundKey  output  64  current round key; feeds AddRoundKey roundKey
- roundIdx  output  4  index (0..NR) of the key on roundKey
- keyValid  output  1  roundKey/roundIdx are valid
- keyReady  input  1  consumer accepts the key when keyValid && keyReady
- done  output  1  one-cycle pulse in the cycle after the final key is accepted

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; roundKey=0, roundIdx=0, keyValid=0, busy=0, done=0. Reset in any state aborts the expansion with no done pulse.
- Key words: w0=key[63:48], w1=[47:32], w2=[31:16], w3=[15:0].
- g(w,i) = SubNib(w rotated left 4 bits) XOR {RCON[i],12'h000}. SubNib applies SBOX to each of the 4 nibbles.
- Next key from current key for round i (1..NR):
  - w0' = w0 ^ g(w3,i)
  - w1' = w1 ^ w0'
  - w2' = w2 ^ w1'
  - w3' = w3 ^ w2'
- SBOX[0..F] = 9,4,A,B,D,1,8,5,6,2,0,3,C,E,F,7.
- RCON[1..10] = 1,2,4,8,3,6,C,B,5,A.
- States:
  - IDLE: keyValid=0, busy=0. On start=1: capture cipherKey into roundKey, roundIdx=0, keyValid=1, busy=1, go to EMIT. The key is valid in the cycle after start (latency 1).
  - EMIT: hold roundKey/roundIdx/keyValid stable while keyReady=0.
    - On handshake with roundIdx<NR: load the next key, roundIdx+1, keyValid stays 1. Back-to-back acceptance gives one key per cycle.
    - On handshake with roundIdx==NR: keyValid=0, busy=0, done=1 for one cycle, go to IDLE.
- start is ignored while busy, including on the done cycle; a new start is honoured from the cycle after done.
- roundKey holds its last value in IDLE; only keyValid qualifies it.
- Expansion is purely combinational from the registered roundKey; there is no precomputed key storage.
- All arithmetic is XOR. No carries; widths are exact.

Decomposition:
- Package saes_pkg holds:
  - STATE_W=64, WORD_W=16, NIB_W=4
  - the SBOX nibble table as a 16-entry constant
  - the RCON table (10 entries)
  - the state enum (IDLE, EMIT)
- Sub-module sbox_nibble: 4-bit combinational S-box lookup, instantiated 4 times for SubNib. The same module is reused later by the SubNibbles stage.

Test Plan:
- Reset then start with cipherKey=0, keyReady=1 -> keys in consecutive cycles:
  - idx0 = 0000000000000000
  - idx1 = 8999899989998999
  - idx2 = 8BBF02268BBF0226
  - then done pulses one cycle after idx4 is accepted; busy is low afterwards.
- cipherKey=0, keyReady held 0 for 3 cycles at idx1 -> roundKey=8999899989998999 and roundIdx=1 stay stable with keyValid=1. Raise keyReady -> idx2 appears the next cycle.
- Assert start again while busy (at idx2) with cipherKey=FFFFFFFFFFFFFFFF -> ignored; the sequence continues with the cipherKey=0 keys.
- Assert rst mid-expansion at idx3 -> next cycle keyValid=0, busy=0, roundKey=0, no done. A fresh start with cipherKey=0 then restarts from idx0.
- NR=1 build, cipherKey=0 -> exactly two keys (0, then 8999899989998999), then done.
- Randomised keys compared against a bench reference model of the recurrence; count NR+1 keys per start, with random keyReady throttling.
